// File: rtl/riscv_pkg.sv
// Shared RV64 integer decode constants and the ALU issue bundle.
package riscv_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned REGB_W     = 12;
    localparam int unsigned ISSUE_OP_W = 10;

    // Major opcodes accepted by the integer issue path
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OP        = 7'h33;
    localparam logic [6:0] OP_32     = 7'h3B;

    // funct7 variants
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // {funct3, opcode} issue encodings shared with the ALU
    localparam logic [ISSUE_OP_W-1:0] ALU_ADDI  = {3'b000, OP_IMM};
    localparam logic [ISSUE_OP_W-1:0] ALU_SLLI  = {3'b001, OP_IMM};
    localparam logic [ISSUE_OP_W-1:0] ALU_XORI  = {3'b100, OP_IMM};
    localparam logic [ISSUE_OP_W-1:0] ALU_ADDIW = {3'b000, OP_IMM_32};
    localparam logic [ISSUE_OP_W-1:0] ALU_ADD   = {3'b000, OP};
    localparam logic [ISSUE_OP_W-1:0] ALU_XOR   = {3'b100, OP};
    localparam logic [ISSUE_OP_W-1:0] ALU_ADDW  = {3'b000, OP_32};

    typedef struct packed {
        logic [REG_IDX_W-1:0]  regA;
        logic [REGB_W-1:0]     regB;
        logic [ISSUE_OP_W-1:0] opcode;
        logic [REG_IDX_W-1:0]  regDest;
    } issue_t;

    function automatic logic is_legal_major(input logic [6:0] op);
        return (op == OP_IMM) || (op == OP_IMM_32) || (op == OP) || (op == OP_32);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP) || (op == OP_32);
    endfunction

    function automatic issue_t decode_issue(input logic [INST_W-1:0] inst);
        issue_t f;
        f.regA    = inst[19:15];
        f.regB    = inst[31:20];
        f.opcode  = {inst[14:12], inst[6:0]};
        f.regDest = inst[11:7];
        return f;
    endfunction

endpackage

// File: rtl/scoreboard.sv
// Per-register busy bits; set wins over a same-cycle clear, x0 never busy.
module scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_set_en,
    input  logic [IDX_W-1:0] i_set_idx,
    input  logic             i_clr_en,
    input  logic [IDX_W-1:0] i_clr_idx,
    input  logic [IDX_W-1:0] i_rs1_idx,
    input  logic [IDX_W-1:0] i_rs2_idx,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rs1_busy_c,
    output logic             o_rs2_busy_c,
    output logic             o_rd_busy_c
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Next busy vector: clear first so a same-index set overrides it
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) w_busy_nxt[i_clr_idx] = 1'b0;
        if (i_set_en) w_busy_nxt[i_set_idx] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Busy register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_busy <= '0;
        else       r_busy <= w_busy_nxt;
    end

    assign o_rs1_busy_c = r_busy[i_rs1_idx];
    assign o_rs2_busy_c = r_busy[i_rs2_idx];
    assign o_rd_busy_c  = r_busy[i_rd_idx];

endmodule

// File: rtl/issue_stage.sv
// Decode/hold stage between fetch and the ALU: D and O registers, hazard
// check against the scoreboard, illegal-word drop and a stall counter.
module issue_stage
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [INST_W-1:0]      in_inst,
    output logic                   in_ready,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [REG_IDX_W-1:0]   issue_regA,
    output logic [REGB_W-1:0]      issue_regB,
    output logic [ISSUE_OP_W-1:0]  issue_opcode,
    output logic [REG_IDX_W-1:0]   issue_regDest,
    input  logic                   wb_valid,
    input  logic [REG_IDX_W-1:0]   wb_reg,
    output logic                   illegal_inst,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic                   r_d_valid;
    logic [INST_W-1:0]      r_d_inst;
    logic                   r_o_valid;
    issue_t                 r_o_issue;
    logic                   r_illegal;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [6:0]             w_major;
    logic                   w_legal;
    logic                   w_uses_rs2;
    logic [REG_IDX_W-1:0]   w_rs1;
    logic [REG_IDX_W-1:0]   w_rs2;
    logic [REG_IDX_W-1:0]   w_rd;
    logic                   w_rs1_busy;
    logic                   w_rs2_busy;
    logic                   w_rd_busy;
    logic                   w_hazard;
    logic                   w_d_advance;
    logic                   w_d_drop;
    logic                   w_stall;
    logic                   w_accept;
    logic                   w_sb_set;

    // Decode of the word sitting in D
    always_comb begin
        w_major    = r_d_inst[6:0];
        w_legal    = is_legal_major(w_major);
        w_uses_rs2 = reads_rs2(w_major);
        w_rs1      = r_d_inst[19:15];
        w_rs2      = r_d_inst[24:20];
        w_rd       = r_d_inst[11:7];
    end

    // Handshake and hazard qualifiers
    always_comb begin
        w_hazard    = w_rs1_busy || (w_uses_rs2 && w_rs2_busy) || w_rd_busy;
        w_d_advance = r_d_valid && w_legal && !w_hazard && (!r_o_valid || issue_ready);
        w_d_drop    = r_d_valid && !w_legal;
        w_stall     = r_d_valid && w_legal && w_hazard;
        w_sb_set    = w_d_advance && (w_rd != '0);
        in_ready    = !r_d_valid || w_d_advance;
        w_accept    = in_valid && in_ready;
    end

    scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_IDX_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .i_set_en     (w_sb_set),
        .i_set_idx    (w_rd),
        .i_clr_en     (wb_valid),
        .i_clr_idx    (wb_reg),
        .i_rs1_idx    (w_rs1),
        .i_rs2_idx    (w_rs2),
        .i_rd_idx     (w_rd),
        .o_rs1_busy_c (w_rs1_busy),
        .o_rs2_busy_c (w_rs2_busy),
        .o_rd_busy_c  (w_rd_busy)
    );

    // D stage: latch fetched word, empty on advance or illegal drop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_valid <= 1'b0;
            r_d_inst  <= '0;
        end else if (w_accept) begin
            r_d_valid <= 1'b1;
            r_d_inst  <= in_inst;
        end else if (w_d_advance || w_d_drop) begin
            r_d_valid <= 1'b0;
        end
    end

    // O stage: pipeline register, fields frozen while stalled by the ALU
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_o_valid <= 1'b0;
            r_o_issue <= '0;
        end else if (w_d_advance) begin
            r_o_valid <= 1'b1;
            r_o_issue <= decode_issue(r_d_inst);
        end else if (issue_ready) begin
            r_o_valid <= 1'b0;
        end
    end

    // Illegal pulse and saturating hazard-stall counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_illegal <= w_d_drop;
            if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign issue_valid   = r_o_valid;
    assign issue_regA    = r_o_issue.regA;
    assign issue_regB    = r_o_issue.regB;
    assign issue_opcode  = r_o_issue.opcode;
    assign issue_regDest = r_o_issue.regDest;
    assign illegal_inst  = r_illegal;
    assign stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: decode vector table, hand-written hazard and
// backpressure sequences, and a randomized run against a reference model.
module tb_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_regA;
    logic [11:0] issue_regB;
    logic [9:0]  issue_opcode;
    logic [4:0]  issue_regDest;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        illegal_inst;
    logic [31:0] stall_count;

    // Second instance with a narrow counter to exercise saturation
    logic        s_in_ready;
    logic        s_issue_valid;
    logic [4:0]  s_regA;
    logic [11:0] s_regB;
    logic [9:0]  s_opcode;
    logic [4:0]  s_regDest;
    logic        s_illegal;
    logic [2:0]  s_stall;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    issue_stage #(.NUM_REGS(32), .STALL_CNT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_regA(issue_regA), .issue_regB(issue_regB), .issue_opcode(issue_opcode),
        .issue_regDest(issue_regDest), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .illegal_inst(illegal_inst), .stall_count(stall_count)
    );

    issue_stage #(.NUM_REGS(32), .STALL_CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(s_in_ready), .issue_valid(s_issue_valid), .issue_ready(issue_ready),
        .issue_regA(s_regA), .issue_regB(s_regB), .issue_opcode(s_opcode),
        .issue_regDest(s_regDest), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .illegal_inst(s_illegal), .stall_count(s_stall)
    );

    logic [31:0] w_fields;
    assign w_fields = {issue_regA, issue_regB, issue_opcode, issue_regDest};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        in_valid    = 1'b0;
        in_inst     = 32'h0;
        issue_ready = 1'b1;
        wb_valid    = 1'b0;
        wb_reg      = 5'd0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Issue fields as defined for a raw word: {rs1, inst[31:20], funct3, opcode, rd}
    function automatic logic [31:0] dec(input logic [31:0] w);
        return {w[19:15], w[31:20], w[14:12], w[6:0], w[11:7]};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic        legal;
        logic [4:0]  ra;
        logic [11:0] rb;
        logic [9:0]  op;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[10];

    // Reference model state
    bit          m_busy[32];
    logic        m_d_v;
    logic [31:0] m_d_w;
    logic        m_o_v;
    logic [31:0] m_o_f;
    logic        m_ill;
    longint      m_stall;

    logic [31:0] bp_words[3];
    logic [4:0]  issued_q[$];

    initial begin
        vecs[0] = '{32'h00500093, 1'b1, 5'd0,  12'h005, 10'h013, 5'd1};   // addi x1,x0,5
        vecs[1] = '{32'h002081B3, 1'b1, 5'd1,  12'h002, 10'h033, 5'd3};   // add x3,x1,x2
        vecs[2] = '{32'h407302B3, 1'b1, 5'd6,  12'h407, 10'h033, 5'd5};   // sub x5,x6,x7
        vecs[3] = '{32'hFFF5851B, 1'b1, 5'd11, 12'hFFF, 10'h01B, 5'd10};  // addiw x10,x11,-1
        vecs[4] = '{32'h0231023B, 1'b1, 5'd2,  12'h023, 10'h03B, 5'd4};   // mulw x4,x2,x3
        vecs[5] = '{32'h00341393, 1'b1, 5'd8,  12'h003, 10'h093, 5'd7};   // slli x7,x8,3
        vecs[6] = '{32'h0020C4B3, 1'b1, 5'd1,  12'h002, 10'h233, 5'd9};   // xor x9,x1,x2
        vecs[7] = '{32'h00000013, 1'b1, 5'd0,  12'h000, 10'h013, 5'd0};   // nop
        vecs[8] = '{32'h00000003, 1'b0, 5'd0,  12'h000, 10'h000, 5'd0};   // load
        vecs[9] = '{32'h0000006F, 1'b0, 5'd0,  12'h000, 10'h000, 5'd0};   // jal

        // Reset values
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_fields", w_fields, 32'd0);
        chk("rst_illegal", 32'(illegal_inst), 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Decode table: each word alone, two edges from offer to O
        for (int i = 0; i < 10; i++) begin
            do_reset();
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            tick();
            in_valid = 1'b0;
            chk("vec_hold_valid", 32'(issue_valid), 32'd0);
            tick();
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(issue_valid), 32'(vecs[i].legal));
            chk($sformatf("vec%0d_illegal", i), 32'(illegal_inst), 32'(!vecs[i].legal));
            if (vecs[i].legal)
                chk($sformatf("vec%0d_fields", i), w_fields,
                    {vecs[i].ra, vecs[i].rb, vecs[i].op, vecs[i].rd});
        end

        // RAW stall until writeback of x1
        do_reset();
        in_valid = 1'b1;
        in_inst  = 32'h00500093;
        tick();
        in_inst  = 32'h002081B3;
        tick();
        in_valid = 1'b0;
        #1;
        chk("raw_first_issue", 32'(issue_valid), 32'd1);
        chk("raw_first_rd", 32'(issue_regDest), 32'd1);
        chk("raw_in_ready_low", 32'(in_ready), 32'd0);
        chk("raw_stall0", stall_count, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            #1;
            chk($sformatf("raw_stall%0d", k), stall_count, 32'(k));
            chk("raw_held", 32'(issue_valid), 32'd0);
        end
        wb_valid = 1'b1;
        wb_reg   = 5'd1;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("raw_wb_edge_valid", 32'(issue_valid), 32'd0);
        chk("raw_wb_edge_stall", stall_count, 32'd4);
        tick();
        #1;
        chk("raw_issue_valid", 32'(issue_valid), 32'd1);
        chk("raw_issue_fields", w_fields, {5'd1, 12'h002, 10'h033, 5'd3});
        chk("raw_stall_final", stall_count, 32'd4);

        // Illegal load to x1 leaves the scoreboard untouched
        do_reset();
        in_valid = 1'b1;
        in_inst  = 32'h00002083;
        tick();
        in_valid = 1'b0;
        #1;
        chk("ill_in_ready", 32'(in_ready), 32'd0);
        chk("ill_pre", 32'(illegal_inst), 32'd0);
        tick();
        #1;
        chk("ill_pulse", 32'(illegal_inst), 32'd1);
        chk("ill_no_issue", 32'(issue_valid), 32'd0);
        chk("ill_d_empty", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_inst  = 32'h00108113;
        tick();
        in_valid = 1'b0;
        #1;
        chk("ill_pulse_end", 32'(illegal_inst), 32'd0);
        tick();
        #1;
        chk("ill_next_valid", 32'(issue_valid), 32'd1);
        chk("ill_next_fields", w_fields, {5'd1, 12'h001, 10'h013, 5'd2});
        chk("ill_next_stall", stall_count, 32'd0);

        // Backpressure: ALU not ready for five cycles
        do_reset();
        bp_words[0] = 32'h00500093;
        bp_words[1] = 32'h00600113;
        bp_words[2] = 32'h00700193;
        issued_q.delete();
        begin
            int p;
            logic acc;
            p = 0;
            for (int c = 0; c < 10; c++) begin
                in_valid    = (p < 3);
                in_inst     = (p < 3) ? bp_words[p] : 32'h0;
                issue_ready = (c >= 5);
                #1;
                if (c >= 2 && c <= 4) begin
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_valid", 32'(issue_valid), 32'd1);
                    chk("bp_stable", w_fields, {5'd0, 12'h005, 10'h013, 5'd1});
                end
                if (issue_valid && issue_ready) issued_q.push_back(issue_regDest);
                acc = in_valid && in_ready;
                tick();
                if (acc) p++;
            end
        end
        chk("bp_count", 32'(issued_q.size()), 32'd3);
        for (int j = 0; j < 3; j++)
            if (j < issued_q.size()) chk("bp_order", 32'(issued_q[j]), 32'(j + 1));

        // Same-cycle set and clear of x5: set wins
        do_reset();
        in_valid = 1'b1;
        in_inst  = 32'h00100293;
        tick();
        in_inst  = 32'h00028313;
        wb_valid = 1'b1;
        wb_reg   = 5'd5;
        #1;
        chk("sw_advance", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wb_valid = 1'b0;
        #1;
        chk("sw_issue_rd", 32'(issue_regDest), 32'd5);
        chk("sw_stall0", stall_count, 32'd0);
        tick();
        #1;
        chk("sw_busy_kept", stall_count, 32'd1);
        chk("sw_held", 32'(issue_valid), 32'd0);
        tick();

        // Asynchronous reset while stalled
        reset = 1'b1;
        #1;
        chk("ar_valid", 32'(issue_valid), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_stall", stall_count, 32'd0);
        chk("ar_fields", w_fields, 32'd0);
        chk("ar_sat_stall", 32'(s_stall), 32'd0);
        reset = 1'b0;
        #1;
        in_valid = 1'b1;
        in_inst  = 32'h00500093;
        wb_valid = 1'b1;
        wb_reg   = 5'd5;
        tick();
        in_inst  = 32'h00028313;
        wb_valid = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        chk("ar_first", 32'(issue_valid), 32'd1);
        chk("ar_first_rd", 32'(issue_regDest), 32'd1);
        tick();
        #1;
        chk("ar_second", 32'(issue_valid), 32'd1);
        chk("ar_second_rd", 32'(issue_regDest), 32'd6);
        chk("ar_no_stall", stall_count, 32'd0);

        // Randomized run against the reference model
        do_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_d_v = 1'b0; m_d_w = '0; m_o_v = 1'b0; m_o_f = '0; m_ill = 1'b0; m_stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [6:0]  op7;
            logic        legal, two_src, haz, adv, e_rdy;
            logic [4:0]  rs1, rs2, rd;
            logic [6:0]  rop, rf7;
            int          sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: rop = 7'h13;
                3:       rop = 7'h1B;
                4, 5, 6: rop = 7'h33;
                7:       rop = 7'h3B;
                8:       rop = 7'h03;
                default: rop = 7'h6F;
            endcase
            case ($urandom_range(0, 2))
                0:       rf7 = 7'b0000000;
                1:       rf7 = 7'b0000001;
                default: rf7 = 7'b0100000;
            endcase
            in_inst     = {rf7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rop};
            in_valid    = ($urandom_range(0, 3) != 0);
            issue_ready = ($urandom_range(0, 9) < 7);
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_reg      = 5'($urandom_range(0, 7));
            #1;
            op7     = m_d_w[6:0];
            legal   = (op7 == 7'h13) || (op7 == 7'h1B) || (op7 == 7'h33) || (op7 == 7'h3B);
            two_src = (op7 == 7'h33) || (op7 == 7'h3B);
            rs1     = m_d_w[19:15];
            rs2     = m_d_w[24:20];
            rd      = m_d_w[11:7];
            haz     = m_busy[rs1] || (two_src && m_busy[rs2]) || m_busy[rd];
            adv     = m_d_v && legal && !haz && (!m_o_v || issue_ready);
            e_rdy   = !m_d_v || adv;
            chk("rnd_in_ready", 32'(in_ready), 32'(e_rdy));
            chk("rnd_valid", 32'(issue_valid), 32'(m_o_v));
            chk("rnd_fields", w_fields, m_o_f);
            chk("rnd_illegal", 32'(illegal_inst), 32'(m_ill));
            chk("rnd_stall", stall_count, 32'(m_stall));
            chk("rnd_sat_stall", 32'(s_stall), (m_stall > 7) ? 32'd7 : 32'(m_stall));
            if (m_d_v && legal && haz) m_stall++;
            if (wb_valid) m_busy[wb_reg] = 1'b0;
            if (adv && rd != 5'd0) m_busy[rd] = 1'b1;
            if (adv) begin
                m_o_v = 1'b1;
                m_o_f = dec(m_d_w);
            end else if (issue_ready) begin
                m_o_v = 1'b0;
            end
            m_ill = m_d_v && !legal;
            if (in_valid && e_rdy) begin
                m_d_v = 1'b1;
                m_d_w = in_inst;
            end else if (m_d_v && (adv || !legal)) begin
                m_d_v = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
